// File: rtl/word_fetch_buffer_pkg.sv
// Shared sizing constants, sentence terminator and FSM encoding for the
// word fetch buffer.
package word_fetch_buffer_pkg;

  localparam int WORD_NUM_BIT = 8;
  localparam int W_BIT        = 4;
  localparam int DEPTH        = 2 ** W_BIT;

  localparam logic [7:0] TERMINATOR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    SAMPLE,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/word_fetch_buffer_sent_buf_ram.sv
// Sentence storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the fetch FSM only reads entries it has written.
module sent_buf_ram #(
  parameter int WORD_NUM_BIT = 8,
  parameter int W_BIT        = 4,
  parameter int DEPTH        = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [W_BIT-1:0]        waddr,
  input  logic [WORD_NUM_BIT-1:0] wdata,
  input  logic [W_BIT-1:0]        raddr,
  output logic [WORD_NUM_BIT-1:0] rdata
);

  logic [WORD_NUM_BIT-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word_fetch_buffer.sv
// Fetches a sentence of word IDs from the upstream lookup into a local
// buffer, then streams it to the Viterbi core with a valid/ready handshake.
module word_fetch_buffer #(
  parameter int WORD_NUM_BIT = word_fetch_buffer_pkg::WORD_NUM_BIT,
  parameter int W_BIT        = word_fetch_buffer_pkg::W_BIT,
  parameter int DEPTH        = word_fetch_buffer_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [W_BIT-1:0]        word_addr,
  input  logic [WORD_NUM_BIT-1:0] word_in,
  input  logic                    endline_in,
  input  logic                    error_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_NUM_BIT-1:0] out_word,
  output logic [W_BIT-1:0]        out_pos,
  output logic                    out_last,
  output logic [W_BIT:0]          sent_len,
  output logic                    done,
  output logic                    err_flag,
  output logic                    ovf_flag
);

  import word_fetch_buffer_pkg::*;

  localparam logic [W_BIT:0]   FULL_LEN = (W_BIT + 1)'(DEPTH);
  localparam logic [W_BIT:0]   ONE_LEN  = (W_BIT + 1)'(1);
  localparam logic [W_BIT-1:0] ONE_PTR  = W_BIT'(1);

  fetch_state_e            state;
  logic [W_BIT-1:0]        wr_ptr;
  logic [W_BIT-1:0]        rd_ptr;
  logic [WORD_NUM_BIT-1:0] rd_data;
  logic                    wr_en;
  logic                    handshake;
  logic                    at_last;

  // A word is stored only when the sampled lookup is neither a terminator
  // nor an error; endline wins over error when both are raised.
  assign wr_en     = (state == SAMPLE) && !endline_in && !error_in;
  assign handshake = out_valid && out_ready;
  assign at_last   = ({1'b0, rd_ptr} == (sent_len - ONE_LEN));

  sent_buf_ram #(
    .WORD_NUM_BIT (WORD_NUM_BIT),
    .W_BIT        (W_BIT),
    .DEPTH        (DEPTH)
  ) u_sent_buf_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (word_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Stream outputs come straight from registers and the buffer read port, so
  // they cannot move during a stall; gating keeps them at zero outside DRAIN.
  assign word_addr = wr_ptr;
  assign busy      = (state != IDLE);
  assign out_word  = out_valid ? rd_data : '0;
  assign out_pos   = out_valid ? rd_ptr : '0;
  assign out_last  = out_valid && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sent_len  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ADDR;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sent_len <= '0;
            err_flag <= 1'b0;
            ovf_flag <= 1'b0;
          end
        end

        ADDR: begin
          state <= SAMPLE;
        end

        SAMPLE: begin
          if (endline_in) begin
            if (sent_len == '0) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              out_valid <= 1'b1;
              state     <= DRAIN;
            end
          end else if (error_in) begin
            err_flag <= 1'b1;
            sent_len <= '0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            sent_len <= sent_len + ONE_LEN;
            // The write pointer parks on the last entry when the buffer fills.
            if (sent_len == (FULL_LEN - ONE_LEN)) begin
              ovf_flag  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DRAIN;
            end else begin
              wr_ptr <= wr_ptr + ONE_PTR;
              state  <= ADDR;
            end
          end
        end

        DRAIN: begin
          if (handshake) begin
            if (at_last) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + ONE_PTR;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/word_fetch_buffer.md
WORD_FETCH_BUFFER -- requirements
Module: word_fetch_buffer

Interface
REQ-001 SHALL have parameters: WORD_NUM_BIT, default 8, word-ID width; W_BIT, default 4, word-index width; DEPTH, default 16 (2**W_BIT), sentence buffer entries.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching a sentence.
- word_addr  out  W_BIT  word index presented to the upstream word lookup.
- word_in  in  WORD_NUM_BIT  word ID returned for word_addr.
- endline_in  in  1  word_addr hit the 8'hFF sentence terminator.
- error_in  in  1  word ID out of range.
- busy  out  1  not IDLE.
- out_valid  out  1  out_word valid toward the Viterbi core.
- out_ready  in  1  Viterbi core accepts out_word.
- out_word  out  WORD_NUM_BIT  buffered word ID.
- out_pos  out  W_BIT  position of out_word in the sentence.
- out_last  out  1  out_word is the final word.
- sent_len  out  W_BIT+1  stored word count, 0..DEPTH.
- done  out  1  one-cycle pulse at sentence end.
- err_flag  out  1  sticky; last sentence aborted on error_in.
- ovf_flag  out  1  sticky; last sentence truncated at DEPTH.

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, SAMPLE, DRAIN.
REQ-004 SHALL go IDLE->ADDR on start=1, clearing wr_ptr, rd_ptr, sent_len, err_flag and ovf_flag; start SHALL be ignored outside IDLE.
REQ-005 In ADDR, word_addr SHALL equal wr_ptr; the next state SHALL be SAMPLE, with word_addr held stable.
REQ-006 In SAMPLE, when error_in=1 and endline_in=0, the block SHALL set err_flag, force sent_len=0, pulse done and return to IDLE; no word is stored.
REQ-007 In SAMPLE, when endline_in=1, the block SHALL store nothing, pulse done if sent_len=0 and go to IDLE, else go to DRAIN; endline_in SHALL take priority over error_in.
REQ-008 In SAMPLE, otherwise the block SHALL write word_in to buf[wr_ptr] and increment wr_ptr and sent_len.
REQ-009 After a SAMPLE write, the next state SHALL be DRAIN with ovf_flag set if sent_len reaches DEPTH; wr_ptr SHALL never wrap. Otherwise the next state SHALL be ADDR.
REQ-010 Fetch throughput SHALL be one word per 2 cycles.
REQ-011 In DRAIN, out_valid SHALL be 1, with out_word=buf[rd_ptr], out_pos=rd_ptr and out_last=(rd_ptr==sent_len-1); these outputs are registered or driven directly from buffer and pointer, with no combinational path from out_ready.
REQ-012 On out_valid&&out_ready, rd_ptr SHALL increment; on the out_last handshake, out_valid SHALL drop next cycle, done SHALL pulse and the FSM SHALL return to IDLE.
REQ-013 Outputs SHALL be held unchanged while out_valid=1 and out_ready=0.
REQ-014 sent_len, err_flag and ovf_flag SHALL hold their values in IDLE until the next accepted start.
REQ-015 busy SHALL be 1 in ADDR, SAMPLE and DRAIN.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE and clear to zero: wr_ptr, rd_ptr, word_addr, out_valid, out_word, out_pos, out_last, sent_len, done, err_flag, ovf_flag and busy; buffer contents are don't-care.
REQ-017 Reset mid-fetch or mid-drain SHALL discard the sentence with no done pulse.

Structure
REQ-018 A shared package SHALL hold WORD_NUM_BIT, W_BIT, DEPTH, the terminator constant 8'hFF, and the FSM state enum.
REQ-019 The buffer SHALL be a sub-module sent_buf_ram with 1 write port and 1 asynchronous read port, DEPTH x WORD_NUM_BIT.

Verification
REQ-020 Stimulus: sentence 03,07,12,FF with out_ready=1 -> sent_len=3, out_word 03/07/12 at out_pos 0/1/2, out_last on 12, done one cycle after the final handshake.
REQ-021 Stimulus: terminator at index 0 -> done pulses, sent_len=0, out_valid never asserted.
REQ-022 Stimulus: 16 valid words with no terminator -> ovf_flag=1, sent_len=16, 16 words drained, word_addr never exceeds 15.
REQ-023 Stimulus: error_in=1 at index 2 -> err_flag=1, sent_len=0, done pulse, no out_valid.
REQ-024 Stimulus: out_ready toggled randomly during DRAIN -> every word delivered exactly once, in order, with outputs stable while stalled.
REQ-025 Stimulus: rst_n pulsed low during DRAIN -> all outputs zero immediately; a new start fetches from index 0.
